// File: rtl/mips_pkg.sv
// Shared MiniMIPS definitions: instruction width, opcodes and fetch-state encoding.
package mips_pkg;

   localparam int INSTR_W = 16;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_BEQ   = 4'b0101;
   localparam logic [3:0] OP_LW    = 4'b1000;
   localparam logic [3:0] OP_SW    = 4'b1001;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   typedef enum logic [1:0] {
      FS_FETCH = 2'd0,
      FS_WAIT  = 2'd1,
      FS_HOLD  = 2'd2,
      FS_HALT  = 2'd3
   } fetch_state_e;

   function automatic logic [3:0] get_op(input logic [INSTR_W-1:0] i_word);
      return i_word[INSTR_W-1 -: 4];
   endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational BEQ/BNE resolution: decides whether the branch is taken and
// computes the redirect target (branch PC + 1 + sign-extended 6-bit offset).
module branch_target_calc #(
   parameter int PC_W = 16
) (
   input  logic            i_br_valid,
   input  logic            i_branch,
   input  logic            i_branch_not,
   input  logic            i_alu_zero,
   input  logic [PC_W-1:0] i_br_pc,
   input  logic [5:0]      i_br_imm,
   output logic            o_taken,
   output logic [PC_W-1:0] o_target
);

   logic [PC_W-1:0] w_imm_sext;

   assign w_imm_sext = {{(PC_W-6){i_br_imm[5]}}, i_br_imm};
   assign o_taken    = i_br_valid & ((i_branch & i_alu_zero) | (i_branch_not & ~i_alu_zero));
   assign o_target   = i_br_pc + PC_W'(1) + w_imm_sext;

endmodule

// File: rtl/instr_fetch_unit.sv
// MiniMIPS fetch front end: owns the PC, fetches over a req/ack handshake,
// presents instructions to decode with valid/ready and applies branch redirects.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      HALT_OP  = OP_HALT
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         op,
   output logic [PC_W-1:0]    pc_out,
   input  logic               br_valid,
   input  logic               branch,
   input  logic               branch_not,
   input  logic               alu_zero,
   input  logic [PC_W-1:0]    br_pc,
   input  logic [5:0]         br_imm,
   output logic               halted
);

   localparam logic [1:0] S_FETCH = FS_FETCH;
   localparam logic [1:0] S_WAIT  = FS_WAIT;
   localparam logic [1:0] S_HOLD  = FS_HOLD;
   localparam logic [1:0] S_HALT  = FS_HALT;

   logic [1:0]         r_state;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    r_addr;
   logic               r_req;
   logic               r_discard;
   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc_out;
   logic               r_instr_valid;
   logic               r_halted;

   logic               w_taken;
   logic [PC_W-1:0]    w_target;
   logic [3:0]         w_op;

   branch_target_calc #(
      .PC_W(PC_W)
   ) u_btc (
      .i_br_valid  (br_valid),
      .i_branch    (branch),
      .i_branch_not(branch_not),
      .i_alu_zero  (alu_zero),
      .i_br_pc     (br_pc),
      .i_br_imm    (br_imm),
      .o_taken     (w_taken),
      .o_target    (w_target)
   );

   assign w_op = get_op(r_instr);

   // The request address is latched separately from the PC so a redirect
   // during an outstanding fetch cannot disturb the address memory is serving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_addr        <= RESET_PC;
         r_req         <= 1'b0;
         r_discard     <= 1'b0;
         r_instr       <= '0;
         r_pc_out      <= '0;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_taken) begin
                  r_pc <= w_target;
               end else begin
                  r_req   <= 1'b1;
                  r_addr  <= r_pc;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  r_req <= 1'b0;
                  if (w_taken || r_discard) begin
                     r_discard <= 1'b0;
                     r_state   <= S_FETCH;
                     if (w_taken) begin
                        r_pc <= w_target;
                     end
                  end else begin
                     r_instr       <= imem_rdata;
                     r_pc_out      <= r_pc;
                     r_pc          <= r_pc + PC_W'(1);
                     r_instr_valid <= 1'b1;
                     r_state       <= S_HOLD;
                  end
               end else if (w_taken) begin
                  r_pc      <= w_target;
                  r_discard <= 1'b1;
               end
            end
            S_HOLD: begin
               // A taken redirect wins over acceptance; the held word is dropped.
               if (w_taken) begin
                  r_pc          <= w_target;
                  r_instr_valid <= 1'b0;
                  r_state       <= S_FETCH;
               end else if (instr_ready) begin
                  r_instr_valid <= 1'b0;
                  if (w_op == HALT_OP) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_HALT: begin
               if (w_taken) begin
                  r_pc     <= w_target;
                  r_halted <= 1'b0;
                  r_state  <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign op          = w_op;
   assign pc_out      = r_pc_out;
   assign halted      = r_halted;

endmodule
